// File: rtl/tone_sequencer.sv
// Multi-voice square-wave tone sequencer: plays a note table from a synchronous
// ROM and streams the mixed, saturated, attenuated sample to Audio_Controller.
module tone_sequencer #(
  parameter int NUM_VOICES = 2,
  parameter int ADDR_W     = 10,
  parameter int PERIOD_W   = 19,
  parameter int DUR_W      = 8,
  parameter int TICK_DIV   = 50000,
  parameter int SAMPLE_W   = 32,
  parameter int AMP        = 10000000
) (
  input  logic                               CLOCK_50,
  input  logic                               resetn,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               loop_en,
  input  logic [2:0]                         vol,
  output logic [ADDR_W-1:0]                  rom_addr,
  input  logic [NUM_VOICES*PERIOD_W+DUR_W-1:0] rom_data,
  input  logic                               audio_out_allowed,
  output logic                               write_audio_out,
  output logic [SAMPLE_W-1:0]                left_channel_audio_out,
  output logic [SAMPLE_W-1:0]                right_channel_audio_out,
  output logic                               busy,
  output logic                               done
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | rom_addr presented to the table ROM
  // LOAD  | table word valid; decode marker or load voices
  // PLAY  | voices running, duration ticking down
  // DONE  | one-cycle done pulse before IDLE
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;

  localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic signed [SUM_W-1:0] AMP_P   = SUM_W'(longint'(AMP));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((longint'(1) << (SAMPLE_W-1)) - longint'(1));
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

  state_t                  state_q;
  logic [PERIOD_W-1:0]     period_q  [NUM_VOICES];
  logic [PERIOD_W-1:0]     counter_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]   phase_q;
  logic [DUR_W-1:0]        remaining_q;
  logic [PRE_W-1:0]        pre_q;
  logic [SAMPLE_W-1:0]     sample_q;
  logic                    busy_q;
  logic                    done_q;

  logic signed [SUM_W-1:0] mix_sum;
  logic signed [SUM_W-1:0] mix_sat;
  logic [SAMPLE_W-1:0]     mix_out;
  logic                    tick;
  logic                    note_end;

  assign tick     = (pre_q == PRE_W'(TICK_DIV - 1));
  assign note_end = tick && (remaining_q == DUR_W'(1));

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (period_q[v] != '0)
        mix_sum = mix_sum + (phase_q[v] ? AMP_P : -AMP_P);
    end
    if (mix_sum > SAT_MAX)
      mix_sat = SAT_MAX;
    else if (mix_sum < SAT_MIN)
      mix_sat = SAT_MIN;
    else
      mix_sat = mix_sum;
    mix_out = SAMPLE_W'(mix_sat >>> vol);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rom_addr    <= '0;
      remaining_q <= '0;
      pre_q       <= '0;
      sample_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phase_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        period_q[v]  <= '0;
        counter_q[v] <= '0;
      end
    end else if (stop) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      pre_q       <= '0;
      sample_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phase_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        period_q[v]  <= '0;
        counter_q[v] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      sample_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            rom_addr <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          if (rom_data[DUR_W-1:0] == '0) begin
            if (loop_en) begin
              rom_addr <= '0;
              state_q  <= S_FETCH;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              period_q[v]  <= rom_data[DUR_W + v*PERIOD_W +: PERIOD_W];
              counter_q[v] <= '0;
            end
            phase_q     <= '1;
            remaining_q <= rom_data[DUR_W-1:0];
            pre_q       <= '0;
            state_q     <= S_PLAY;
          end
        end
        S_PLAY: begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (period_q[v] != '0) begin
              if (counter_q[v] == period_q[v] - PERIOD_W'(1)) begin
                counter_q[v] <= '0;
                phase_q[v]   <= ~phase_q[v];
              end else begin
                counter_q[v] <= counter_q[v] + PERIOD_W'(1);
              end
            end
          end
          pre_q <= tick ? '0 : pre_q + PRE_W'(1);
          if (tick)
            remaining_q <= remaining_q - DUR_W'(1);
          // The register stays zero in every non-PLAY cycle, including the FETCH after a note.
          if (note_end) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            state_q  <= S_FETCH;
          end else begin
            sample_q <= mix_out;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign write_audio_out         = audio_out_allowed & (state_q == S_PLAY);
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign busy                    = busy_q;
  assign done                    = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized self-checking bench for tone_sequencer against a timeline model
// built from note durations and square-wave arithmetic.
module tb_tone_sequencer;

  localparam int NV  = 2;
  localparam int AW  = 2;
  localparam int PW  = 6;
  localparam int DW  = 4;
  localparam int TD  = 4;
  localparam int SW  = 32;
  localparam int AMP = 1 << 30;

  logic          CLOCK_50;
  logic          resetn;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [2:0]    vol;
  logic [AW-1:0] rom_addr;
  logic [NV*PW+DW-1:0] rom_data;
  logic          audio_out_allowed;
  logic          write_audio_out;
  logic [SW-1:0] left_channel_audio_out;
  logic [SW-1:0] right_channel_audio_out;
  logic          busy;
  logic          done;

  logic [NV*PW+DW-1:0] rom_mem [4];

  int total;
  int bad;

  typedef struct {
    bit     busy;
    bit     done;
    bit     play;
    int     addr;
    longint sample;
  } exp_t;
  exp_t exp_q[$];

  tone_sequencer #(
    .NUM_VOICES(NV), .ADDR_W(AW), .PERIOD_W(PW), .DUR_W(DW),
    .TICK_DIV(TD), .SAMPLE_W(SW), .AMP(AMP)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
    .vol(vol),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .busy(busy),
    .done(done)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  always @(posedge CLOCK_50) rom_data <= rom_mem[rom_addr];

  function automatic logic [15:0] word(input int p0, input int p1, input int d);
    logic [5:0] a;
    logic [5:0] b;
    logic [3:0] c;
    a = p0[5:0];
    b = p1[5:0];
    c = d[3:0];
    return {b, a, c};
  endfunction

  // Sample implied by the voice phases during PLAY cycle k (1-based) of note a.
  function automatic longint exp_mix(input int a, input int k, input int v);
    longint s;
    longint lim;
    int p [2];
    p[0] = int'(rom_mem[a][9:4]);
    p[1] = int'(rom_mem[a][15:10]);
    s = 0;
    for (int i = 0; i < NV; i++) begin
      if (p[i] != 0)
        s += ((((k - 1) / p[i]) % 2) == 0) ? longint'(AMP) : -longint'(AMP);
    end
    lim = (longint'(1) << (SW - 1)) - 1;
    if (s > lim) s = lim;
    if (s < -lim) s = -lim;
    return s >>> v;
  endfunction

  task automatic push_exp(input bit b, input bit d, input bit p, input int a, input longint s);
    exp_t e;
    e.busy = b; e.done = d; e.play = p; e.addr = a; e.sample = s;
    exp_q.push_back(e);
  endtask

  task automatic build_expect(input int n, input bit lp, input int v);
    int a;
    int d;
    exp_q.delete();
    a = 0;
    while (exp_q.size() < n) begin
      push_exp(1, 0, 0, a, 0);
      push_exp(1, 0, 0, a, 0);
      d = int'(rom_mem[a][3:0]);
      if (d == 0) begin
        if (lp) a = 0;
        else begin
          push_exp(0, 1, 0, a, 0);
          while (exp_q.size() < n) push_exp(0, 0, 0, a, 0);
        end
      end else begin
        for (int k = 1; k <= d * TD; k++)
          push_exp(1, 0, 1, a, (k == 1) ? 0 : exp_mix(a, k - 1, v));
        a = (a + 1) % 4;
      end
    end
  endtask

  function automatic int table_len();
    int n;
    n = 0;
    for (int a = 0; a < 4; a++) begin
      n += 2;
      if (rom_mem[a][3:0] == 0) return n + 2;
      n += int'(rom_mem[a][3:0]) * TD;
    end
    return n;
  endfunction

  // allow_mode: 0 random, 1 always high, 2 low for the first 5 PLAY cycles
  task automatic run_check(input string name, input int n, input bit lp, input int v, input int allow_mode);
    int play_seen;
    longint act;
    exp_t e;
    play_seen = 0;
    loop_en = lp;
    vol = v[2:0];
    build_expect(n, lp, v);
    @(negedge CLOCK_50);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
      start = 1'b0;
      e = exp_q[i];
      case (allow_mode)
        0: audio_out_allowed = ($urandom_range(0, 1) == 1);
        1: audio_out_allowed = 1'b1;
        default: audio_out_allowed = !(e.play && play_seen < 5);
      endcase
      if (e.play) play_seen++;
      #1;
      act = longint'($signed(left_channel_audio_out));
      total++;
      if (busy !== e.busy) begin
        bad++;
        $display("FAIL %s busy cyc=%0d got=%0b exp=%0b", name, i, busy, e.busy);
      end
      total++;
      if (done !== e.done) begin
        bad++;
        $display("FAIL %s done cyc=%0d got=%0b exp=%0b", name, i, done, e.done);
      end
      total++;
      if (int'(rom_addr) !== e.addr) begin
        bad++;
        $display("FAIL %s rom_addr cyc=%0d got=%0d exp=%0d", name, i, rom_addr, e.addr);
      end
      total++;
      if (act !== e.sample) begin
        bad++;
        $display("FAIL %s sample cyc=%0d got=%0d exp=%0d", name, i, act, e.sample);
      end
      total++;
      if (right_channel_audio_out !== left_channel_audio_out) begin
        bad++;
        $display("FAIL %s right_ch cyc=%0d got=%0h exp=%0h", name, i, right_channel_audio_out, left_channel_audio_out);
      end
      total++;
      if (write_audio_out !== (e.play && audio_out_allowed)) begin
        bad++;
        $display("FAIL %s write cyc=%0d got=%0b exp=%0b", name, i, write_audio_out, e.play && audio_out_allowed);
      end
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || write_audio_out !== 1'b0 || left_channel_audio_out !== '0) begin
      bad++;
      $display("FAIL %s idle got busy=%0b done=%0b write=%0b sample=%0h exp all 0",
               name, busy, done, write_audio_out, left_channel_audio_out);
    end
  endtask

  task automatic do_stop(input string name, input bit with_start);
    @(negedge CLOCK_50);
    stop = 1'b1;
    start = with_start;
    audio_out_allowed = 1'b1;
    @(posedge CLOCK_50);
    #1;
    stop = 1'b0;
    start = 1'b0;
    check_idle(name);
    @(posedge CLOCK_50);
    #1;
    check_idle(name);
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; vol = 3'd0; audio_out_allowed = 1'b1;
    #2 resetn = 1'b0;
    #1;
    total++;
    if (rom_addr !== '0) begin
      bad++;
      $display("FAIL reset rom_addr got=%0d exp=0", rom_addr);
    end
    check_idle("reset");
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check_idle("reset_release");
  endtask

  task automatic test_single_note();
    rom_mem[0] = word(2, 0, 2);
    rom_mem[1] = word(0, 0, 0);
    rom_mem[2] = word(0, 0, 0);
    rom_mem[3] = word(0, 0, 0);
    run_check("single_note", table_len() + 1, 1'b0, 0, 1);
  endtask

  task automatic test_two_voices();
    rom_mem[0] = word(3, 0, 2);
    rom_mem[1] = word(3, 3, 2);
    rom_mem[2] = word(0, 0, 0);
    run_check("two_voice_v0", table_len() + 1, 1'b0, 0, 1);
    run_check("two_voice_v1", table_len() + 1, 1'b0, 1, 1);
  endtask

  task automatic test_random();
    int nn;
    for (int it = 0; it < 6; it++) begin
      nn = $urandom_range(1, 3);
      for (int a = 0; a < 4; a++) begin
        if (a < nn)
          rom_mem[a] = word($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 4));
        else
          rom_mem[a] = word(0, 0, 0);
      end
      run_check("random", table_len() + 1, 1'b0, $urandom_range(0, 7), 0);
    end
  endtask

  task automatic test_loop();
    rom_mem[0] = word(5, 0, 1);
    rom_mem[1] = word(0, 0, 0);
    run_check("loop", 30, 1'b1, 0, 1);
    do_stop("loop_stop", 1'b0);
  endtask

  task automatic test_stop_restart();
    rom_mem[0] = word(3, 2, 3);
    rom_mem[1] = word(0, 0, 0);
    run_check("stop_pre", 7, 1'b0, 0, 1);
    do_stop("stop_start", 1'b1);
    run_check("replay", table_len() + 1, 1'b0, 0, 1);
  endtask

  task automatic test_handshake();
    rom_mem[0] = word(2, 1, 3);
    rom_mem[1] = word(0, 0, 0);
    run_check("handshake", table_len() + 1, 1'b0, 2, 2);
  endtask

  task automatic test_addr_wrap();
    rom_mem[0] = word(1, 0, 1);
    rom_mem[1] = word(2, 0, 1);
    rom_mem[2] = word(3, 4, 1);
    rom_mem[3] = word(4, 1, 1);
    run_check("addr_wrap", 4 * (2 + TD) + 6, 1'b0, 0, 0);
    do_stop("wrap_stop", 1'b0);
  endtask

  task automatic test_async_reset();
    rom_mem[0] = word(2, 3, 2);
    rom_mem[1] = word(0, 0, 0);
    run_check("areset_pre", 6, 1'b0, 0, 1);
    #1 resetn = 1'b0;
    #1;
    total++;
    if (rom_addr !== '0) begin
      bad++;
      $display("FAIL async_reset rom_addr got=%0d exp=0", rom_addr);
    end
    check_idle("async_reset");
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check_idle("async_reset_after");
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int a = 0; a < 4; a++) rom_mem[a] = '0;
    test_reset();
    test_single_note();
    test_two_voices();
    test_random();
    test_loop();
    test_stop_restart();
    test_handshake();
    test_addr_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
